// File: rtl/keysw_io_dev.sv
// Memory-mapped KEY/SW input device: synchronizes and debounces the pins, latches ready/overrun per bus.
// Optional feature macro: KEYSW_IRQ_EN adds writable interrupt-enable bits and a registered irq output.

module keysw_debounce #(
   parameter int W        = 4,
   parameter int DEBOUNCE = 10000,
   parameter int CNTBITS  = 14,
   parameter bit INVERT   = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_pins,
   output logic [W-1:0] o_stable,
   output logic         o_commit
);
   localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE - 1);

   logic [W-1:0]       r_sync1;
   logic [W-1:0]       r_sync2;
   logic [W-1:0]       r_stable;
   logic [CNTBITS-1:0] r_cnt;
   logic [W-1:0]       w_sync;
   logic               w_changed;
   logic               w_pending;

   assign w_sync    = INVERT ? ~r_sync2 : r_sync2;
   // The first stage already holds next cycle's sync value, so a difference between
   // the stages is exactly a change of sync relative to its previous-cycle value.
   assign w_changed = (r_sync1 != r_sync2);
   assign w_pending = (w_sync != r_stable);
   assign o_commit  = !w_changed && w_pending && (r_cnt == CNT_LAST);
   assign o_stable  = r_stable;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_pins;
         r_sync2 <= r_sync1;
         if (w_changed || !w_pending) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
endmodule

module keysw_io_dev #(
   parameter int          DBITS    = 32,
   parameter int          KEYBITS  = 4,
   parameter int          SWBITS   = 10,
   parameter logic [31:0] ADDRKEY  = 32'hFFFFF080,
   parameter logic [31:0] ADDRSW   = 32'hFFFFF090,
   parameter int          DEBOUNCE = 10000,
   parameter int          CNTBITS  = 14
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [KEYBITS-1:0] KEY,
   input  logic [SWBITS-1:0]  SW,
   input  logic [DBITS-1:0]   addr,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [DBITS-1:0]   wdata,
   output logic [DBITS-1:0]   rdata,
   output logic               hit,
   output logic               irq
);
   localparam logic [DBITS-1:0] A_KDATA = DBITS'(ADDRKEY);
   localparam logic [DBITS-1:0] A_KCTRL = DBITS'(ADDRKEY + 32'd4);
   localparam logic [DBITS-1:0] A_SDATA = DBITS'(ADDRSW);
   localparam logic [DBITS-1:0] A_SCTRL = DBITS'(ADDRSW + 32'd4);

   logic [KEYBITS-1:0] w_kstable;
   logic [SWBITS-1:0]  w_sstable;
   logic               w_kcommit;
   logic               w_scommit;
   logic               w_hit_kdata;
   logic               w_hit_kctrl;
   logic               w_hit_sdata;
   logic               w_hit_sctrl;
   logic               w_krd_clr;
   logic               w_srd_clr;
   logic               w_kctrl_wr;
   logic               w_sctrl_wr;
   logic               w_kie;
   logic               w_sie;
   logic               w_unused;
   logic               r_kready;
   logic               r_kovr;
   logic               r_sready;
   logic               r_sovr;

   keysw_debounce #(
      .W(KEYBITS), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS), .INVERT(1'b1)
   ) u_key_db (
      .clk(clk), .reset(reset), .i_pins(KEY), .o_stable(w_kstable), .o_commit(w_kcommit)
   );

   keysw_debounce #(
      .W(SWBITS), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS), .INVERT(1'b0)
   ) u_sw_db (
      .clk(clk), .reset(reset), .i_pins(SW), .o_stable(w_sstable), .o_commit(w_scommit)
   );

   assign w_hit_kdata = (addr == A_KDATA);
   assign w_hit_kctrl = (addr == A_KCTRL);
   assign w_hit_sdata = (addr == A_SDATA);
   assign w_hit_sctrl = (addr == A_SCTRL);
   assign hit         = w_hit_kdata | w_hit_kctrl | w_hit_sdata | w_hit_sctrl;

   assign w_krd_clr  = rd_en & w_hit_kdata;
   assign w_srd_clr  = rd_en & w_hit_sdata;
   assign w_kctrl_wr = wr_en & w_hit_kctrl;
   assign w_sctrl_wr = wr_en & w_hit_sctrl;
   assign w_unused   = &{1'b0, wdata};

   // A commit always wins over a clearing read or an overrun-clear write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_kready <= 1'b0;
         r_kovr   <= 1'b0;
         r_sready <= 1'b0;
         r_sovr   <= 1'b0;
      end else begin
         if (w_kcommit)      r_kready <= 1'b1;
         else if (w_krd_clr) r_kready <= 1'b0;
         if (w_kcommit && r_kready && !w_krd_clr) r_kovr <= 1'b1;
         else if (w_kctrl_wr && !wdata[1])        r_kovr <= 1'b0;

         if (w_scommit)      r_sready <= 1'b1;
         else if (w_srd_clr) r_sready <= 1'b0;
         if (w_scommit && r_sready && !w_srd_clr) r_sovr <= 1'b1;
         else if (w_sctrl_wr && !wdata[1])        r_sovr <= 1'b0;
      end
   end

`ifdef KEYSW_IRQ_EN
   logic r_kie;
   logic r_sie;
   logic r_irq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_kie <= 1'b0;
         r_sie <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         if (w_kctrl_wr) r_kie <= wdata[4];
         if (w_sctrl_wr) r_sie <= wdata[4];
         r_irq <= (r_kready & r_kie) | (r_sready & r_sie);
      end
   end

   assign w_kie = r_kie;
   assign w_sie = r_sie;
   assign irq   = r_irq;
`else
   assign w_kie = 1'b0;
   assign w_sie = 1'b0;
   assign irq   = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      if (w_hit_kdata)      rdata = {{(DBITS-KEYBITS){1'b0}}, w_kstable};
      else if (w_hit_kctrl) rdata = {{(DBITS-5){1'b0}}, w_kie, 2'b00, r_kovr, r_kready};
      else if (w_hit_sdata) rdata = {{(DBITS-SWBITS){1'b0}}, w_sstable};
      else if (w_hit_sctrl) rdata = {{(DBITS-5){1'b0}}, w_sie, 2'b00, r_sovr, r_sready};
   end
endmodule

// File: tb/tb_keysw_io_dev.sv
// Directed bench for keysw_io_dev with DEBOUNCE=4; honours KEYSW_IRQ_EN when defined.
`timescale 1ns/1ps
module tb_keysw_io_dev;
   localparam logic [31:0] A_KDATA = 32'hFFFFF080;
   localparam logic [31:0] A_KCTRL = 32'hFFFFF084;
   localparam logic [31:0] A_SDATA = 32'hFFFFF090;
   localparam logic [31:0] A_SCTRL = 32'hFFFFF094;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic [31:0] addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;

   int checks = 0;
   int failures = 0;

   keysw_io_dev #(.DEBOUNCE(4), .CNTBITS(3)) dut (
      .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .addr(addr), .rd_en(rd_en),
      .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      addr = a; rd_en = 1'b0; wr_en = 1'b0;
      #1;
      d = rdata;
   endtask

   task automatic bus_read_strobe(input logic [31:0] a);
      addr = a; rd_en = 1'b1; wr_en = 1'b0;
      @(posedge clk);
      #2;
      rd_en = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
      @(posedge clk);
      #2;
      wr_en = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic [31:0] addrs [4];
      addrs[0] = A_KDATA; addrs[1] = A_KCTRL; addrs[2] = A_SDATA; addrs[3] = A_SCTRL;
      KEY = 4'hF; SW = 10'h000; addr = 32'h0; rd_en = 0; wr_en = 0; wdata = 0;
      reset = 1'b1;
      #1;
      checks++;
      if (irq !== 1'b0) begin
         failures++; $display("FAIL reset_irq_async got=%b want=0", irq);
      end
      wait_edges(3);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         peek(addrs[i], d);
         checks++;
         if (d !== 32'h0 || hit !== 1'b1) begin
            failures++; $display("FAIL reset_reg%0d rdata=%h hit=%b want rdata=0 hit=1", i, d, hit);
         end
      end
      peek(32'hFFFFF088, d);
      checks++;
      if (d !== 32'h0 || hit !== 1'b0) begin
         failures++; $display("FAIL reset_nohit rdata=%h hit=%b want rdata=0 hit=0", d, hit);
      end
      for (int i = 0; i < 20; i++) begin
         wait_edges(1);
         checks++;
         if (irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq_idle cycle=%0d got=%b want=0", i, irq);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_key_debounce;
      logic [31:0] d;
      KEY = 4'hE;
      wait_edges(5);
      peek(A_KDATA, d);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL key_cycle5 got=%h want=0", d);
      end
      wait_edges(1);
      peek(A_KDATA, d);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL key_cycle6 got=%h want=1", d);
      end
      peek(A_KCTRL, d);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL key_ready got=%h want=1", d);
      end
      bus_read_strobe(A_KDATA);
      peek(A_KCTRL, d);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL key_read_clears got=%h want=0", d);
      end
      $display("test_key_debounce done");
   endtask

   task automatic test_sw_glitch;
      logic [31:0] d;
      SW = 10'h3FF;
      wait_edges(3);
      SW = 10'h000;
      wait_edges(10);
      peek(A_SDATA, d);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL sw_glitch_data got=%h want=0", d);
      end
      peek(A_SCTRL, d);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL sw_glitch_ctrl got=%h want=0", d);
      end
      $display("test_sw_glitch done");
   endtask

   task automatic test_sw_overrun;
      logic [31:0] d;
      SW = 10'h005;
      wait_edges(8);
      peek(A_SDATA, d);
      checks++;
      if (d !== 32'h005) begin
         failures++; $display("FAIL sw_first_commit got=%h want=005", d);
      end
      SW = 10'h00A;
      wait_edges(8);
      peek(A_SCTRL, d);
      checks++;
      if (d !== 32'h3) begin
         failures++; $display("FAIL sw_overrun_ctrl got=%h want=3", d);
      end
      peek(A_SDATA, d);
      checks++;
      if (d !== 32'h00A) begin
         failures++; $display("FAIL sw_overrun_data got=%h want=00A", d);
      end
      bus_write(A_SCTRL, 32'h0);
      peek(A_SCTRL, d);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL sw_ovr_clear got=%h want=1", d);
      end
      bus_write(A_SDATA, 32'h3FF);
      peek(A_SDATA, d);
      checks++;
      if (d !== 32'h00A) begin
         failures++; $display("FAIL sw_data_write_ignored got=%h want=00A", d);
      end
      bus_read_strobe(A_SDATA);
      $display("test_sw_overrun done");
   endtask

   task automatic test_read_on_commit;
      logic [31:0] d;
      KEY = 4'hC;
      wait_edges(8);
      peek(A_KCTRL, d);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL roc_pre_ready got=%h want=1", d);
      end
      KEY = 4'h8;
      wait_edges(5);
      bus_read_strobe(A_KDATA);
      peek(A_KCTRL, d);
      checks++;
      if (d !== 32'h1) begin
         failures++; $display("FAIL roc_ctrl got=%h want=1", d);
      end
      peek(A_KDATA, d);
      checks++;
      if (d !== 32'h7) begin
         failures++; $display("FAIL roc_data got=%h want=7", d);
      end
      bus_read_strobe(A_KDATA);
      $display("test_read_on_commit done");
   endtask

   task automatic test_irq;
      logic [31:0] d;
      bus_write(A_KCTRL, 32'h10);
      peek(A_KCTRL, d);
      checks++;
`ifdef KEYSW_IRQ_EN
      if (d !== 32'h10) begin
         failures++; $display("FAIL irq_ie_readback got=%h want=10", d);
      end
`else
      if (d !== 32'h0) begin
         failures++; $display("FAIL irq_ie_readback got=%h want=0", d);
      end
`endif
      KEY = 4'hF;
      wait_edges(6);
      peek(A_KCTRL, d);
      checks++;
`ifdef KEYSW_IRQ_EN
      if (d !== 32'h11 || irq !== 1'b0) begin
         failures++; $display("FAIL irq_ready_edge ctrl=%h irq=%b want ctrl=11 irq=0", d, irq);
      end
      wait_edges(1);
      checks++;
      if (irq !== 1'b1) begin
         failures++; $display("FAIL irq_rise got=%b want=1", irq);
      end
      bus_read_strobe(A_KDATA);
      wait_edges(1);
      checks++;
      if (irq !== 1'b0) begin
         failures++; $display("FAIL irq_fall got=%b want=0", irq);
      end
`else
      if (d !== 32'h1 || irq !== 1'b0) begin
         failures++; $display("FAIL irq_ready_edge ctrl=%h irq=%b want ctrl=1 irq=0", d, irq);
      end
      for (int i = 0; i < 4; i++) begin
         wait_edges(1);
         checks++;
         if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_tied_low cycle=%0d got=%b want=0", i, irq);
         end
      end
      bus_read_strobe(A_KDATA);
`endif
      $display("test_irq done");
   endtask

   initial begin
      test_reset();
      test_key_debounce();
      test_sw_glitch();
      test_sw_overrun();
      test_read_on_commit();
      test_irq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
